// File: rtl/hilo_muldiv.sv
// HI/LO unit for the MIPS execute stage: MTHI/MTLO, single-cycle MULT/MULTU,
// and a 32-step restoring DIV/DIVU that holds the pipeline while it iterates.
module hilo_muldiv (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MTHI  = 3'd1;
    localparam logic [2:0] OP_MTLO  = 3'd2;
    localparam logic [2:0] OP_MULT  = 3'd3;
    localparam logic [2:0] OP_MULTU = 3'd4;
    localparam logic [2:0] OP_DIV   = 3'd5;
    localparam logic [2:0] OP_DIVU  = 3'd6;

    state_t      r_state;
    state_t      w_state_nx;
    logic [4:0]  r_count;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic        r_qsign;
    logic        r_rsign;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_div;
    logic        w_b_nz;
    logic        w_issue;
    logic        w_start;
    logic        w_step;
    logic        w_last;
    logic        w_signed_div;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_a_sx;
    logic [63:0] w_b_sx;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_qbit;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_is_div     = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign w_signed_div = (op_i == OP_DIV);
    assign w_b_nz       = (b_i != 32'd0);
    assign w_issue      = (r_state == S_IDLE) && valid_i && !flush_i;
    assign w_start      = w_issue && w_is_div && w_b_nz;
    assign w_step       = (r_state == S_BUSY) && !flush_i;
    assign w_last       = w_step && (r_count == 5'd31);

    // Stall handshake: while stall_o is high the pipeline holds valid_i/op_i/a_i/b_i
    // unchanged; the instruction retires in the first cycle with valid_i && !stall_o && !flush_i.
    assign stall_o = !flush_i &&
                     (((r_state == S_IDLE) && valid_i && w_is_div && w_b_nz) ||
                      (r_state == S_BUSY));

    assign w_a_mag = (w_signed_div && a_i[31]) ? (32'd0 - a_i) : a_i;
    assign w_b_mag = (w_signed_div && b_i[31]) ? (32'd0 - b_i) : b_i;

    assign w_a_sx   = {{32{a_i[31]}}, a_i};
    assign w_b_sx   = {{32{b_i[31]}}, b_i};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, a_i} * {32'd0, b_i};

    // One restoring step: dividend bits stream out of r_quo's MSB while quotient bits fill its LSB.
    assign w_shift  = {r_rem, r_quo[31]};
    assign w_diff   = w_shift - {1'b0, r_div};
    assign w_qbit   = !w_diff[32];
    assign w_rem_nx = w_qbit ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_nx = {r_quo[30:0], w_qbit};
    assign w_q_fix  = r_qsign ? (32'd0 - w_quo_nx) : w_quo_nx;
    assign w_r_fix  = r_rsign ? (32'd0 - w_rem_nx) : w_rem_nx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nx = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    w_state_nx = S_IDLE;
                end else if (r_count == 5'd31) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= 5'd0;
            r_rem   <= 32'd0;
            r_quo   <= 32'd0;
            r_div   <= 32'd0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
        end else if (w_start) begin
            r_count <= 5'd0;
            r_rem   <= 32'd0;
            r_quo   <= w_a_mag;
            r_div   <= w_b_mag;
            r_qsign <= w_signed_div && (a_i[31] ^ b_i[31]);
            r_rsign <= w_signed_div && a_i[31];
        end else if (w_step) begin
            r_count <= r_count + 5'd1;
            r_rem   <= w_rem_nx;
            r_quo   <= w_quo_nx;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_issue) begin
            case (op_i)
                OP_MTHI:  r_hi <= a_i;
                OP_MTLO:  r_lo <= a_i;
                OP_MULT:  {r_hi, r_lo} <= w_prod_s;
                OP_MULTU: {r_hi, r_lo} <= w_prod_u;
                default: begin
                end
            endcase
        end else if (w_last) begin
            r_hi <= w_r_fix;
            r_lo <= w_q_fix;
        end
    end

    assign hi_o        = r_hi;
    assign lo_o        = r_lo;
    assign dbg_state_o = r_state;

endmodule
